// File: rtl/config_loader.sv
// Master end of the fabric configuration chain: takes bitstream words over a
// valid/ready handshake and shifts them MSB-first into the tile config chain.
module config_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 36
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_in,
  output logic                  config_enable,
  output logic                  config_nreset,
  output logic                  busy,
  output logic                  done
);

  localparam int NUM_WORDS = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int BCW       = $clog2(WORD_WIDTH + 1);
  localparam int WCW       = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [WORD_WIDTH-1:0] r_shreg;
  logic [BCW-1:0]        r_bitCnt;
  logic [WCW-1:0]        r_wordCnt;
  logic                  w_lastBit;
  logic                  w_moreWords;
  logic                  w_take;

  assign w_lastBit   = (r_bitCnt == BCW'(1));
  assign w_moreWords = (r_wordCnt < WCW'(NUM_WORDS));
  assign w_take      = word_valid && word_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // On the last bit of a word the next word may be taken in the same cycle,
  // so a steady source streams with no bubble between words.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nextState = S_CLEAR;
      S_CLEAR: w_nextState = S_LOAD;
      S_LOAD:  if (w_take) w_nextState = S_SHIFT;
      S_SHIFT: begin
        if (w_lastBit) begin
          if (!w_moreWords) begin
            w_nextState = S_DONE;
          end else if (!w_take) begin
            w_nextState = S_LOAD;
          end
        end
      end
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    word_ready    = (r_state == S_LOAD) ||
                    ((r_state == S_SHIFT) && w_lastBit && w_moreWords);
    config_enable = (r_state == S_SHIFT);
    config_in     = (r_state == S_SHIFT) ? r_shreg[WORD_WIDTH-1] : 1'b0;
    config_nreset = (r_state != S_CLEAR);
    busy          = (r_state == S_CLEAR) || (r_state == S_LOAD) ||
                    (r_state == S_SHIFT);
    done          = (r_state == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_shreg   <= '0;
      r_bitCnt  <= '0;
      r_wordCnt <= '0;
    end else begin
      if (w_take) begin
        r_shreg   <= word_data;
        r_bitCnt  <= BCW'(WORD_WIDTH);
        r_wordCnt <= r_wordCnt + WCW'(1);
      end else if (r_state == S_SHIFT) begin
        r_shreg  <= {r_shreg[WORD_WIDTH-2:0], 1'b0};
        r_bitCnt <= r_bitCnt - BCW'(1);
      end
      if (r_state == S_CLEAR) begin
        r_wordCnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: two instances (36-bit chain with padding,
// 32-bit chain without) each driving a behavioural chain shift register.
module tb_config_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic       startA;
  logic       startB;
  logic [7:0] wordData;
  logic       wordValid;
  logic       readyA, cinA, enA, nrstA, busyA, doneA;
  logic       readyB, cinB, enB, nrstB, busyB, doneB;

  logic [35:0] chainA;
  logic [31:0] chainB;
  logic [7:0]  stream [5];

  int checks;
  int failures;

  int nrstLowCount, nrstLowFirst, enCount, enFirst, enLast;
  int doneCount, doneCycle, accepted, readyNoEn;
  logic postEn, postBusy, postReady, postNrst;

  always #5 clock = ~clock;

  config_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(36)) dutA (
    .clock(clock), .reset(reset), .start(startA),
    .word_data(wordData), .word_valid(wordValid), .word_ready(readyA),
    .config_in(cinA), .config_enable(enA), .config_nreset(nrstA),
    .busy(busyA), .done(doneA)
  );

  config_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(32)) dutB (
    .clock(clock), .reset(reset), .start(startB),
    .word_data(wordData), .word_valid(wordValid), .word_ready(readyB),
    .config_in(cinB), .config_enable(enB), .config_nreset(nrstB),
    .busy(busyB), .done(doneB)
  );

  // Behavioural tile chains: new bits enter at bit 0 and move toward the tail.
  always @(posedge clock) begin
    if (!nrstA) chainA <= '0;
    else if (enA) chainA <= {chainA[34:0], cinA};
    if (!nrstB) chainB <= '0;
    else if (enB) chainB <= {chainB[30:0], cinB};
  end

  // Drives one load on the selected instance, cycle 0 being the start cycle,
  // and records when each chain-facing event was observed.
  task automatic runLoad(input bit sel, input int numWords, input int stallAt,
                         input int stallLen, input int restartAt,
                         input int resetAt, input int maxCyc);
    int   idx;
    int   stallLeft;
    logic rdy, en, nr, dn;
    idx = 0;
    stallLeft = stallLen;
    nrstLowCount = 0; nrstLowFirst = -1; enCount = 0; enFirst = -1;
    enLast = -1; doneCount = 0; doneCycle = -1; accepted = 0; readyNoEn = 0;
    for (int cyc = 0; cyc < maxCyc; cyc++) begin
      @(negedge clock);
      rdy = sel ? readyB : readyA;
      en  = sel ? enB    : enA;
      nr  = sel ? nrstB  : nrstA;
      dn  = sel ? doneB  : doneA;
      if (resetAt >= 0 && cyc == resetAt + 1) begin
        postEn    = en;
        postBusy  = sel ? busyB : busyA;
        postReady = rdy;
        postNrst  = nr;
        reset     = 1'b0;
        break;
      end
      if (!nr) begin
        nrstLowCount++;
        if (nrstLowFirst < 0) nrstLowFirst = cyc;
      end
      if (en) begin
        enCount++;
        if (enFirst < 0) enFirst = cyc;
        enLast = cyc;
      end
      if (rdy && !en) readyNoEn++;
      if (dn) begin
        doneCount++;
        doneCycle = cyc;
      end
      startA   = !sel && (cyc == 0 || cyc == restartAt);
      startB   = sel && (cyc == 0 || cyc == restartAt);
      reset    = (cyc == resetAt);
      wordData = (idx < numWords) ? stream[idx] : 8'h00;
      if (idx == stallAt && rdy && stallLeft > 0) begin
        wordValid = 1'b0;
        stallLeft--;
      end else begin
        wordValid = 1'b1;
      end
      if (wordValid && rdy) begin
        accepted++;
        idx++;
      end
    end
    startA    = 1'b0;
    startB    = 1'b0;
    wordValid = 1'b0;
  endtask

  task automatic setStreamA();
    stream[0] = 8'hA5; stream[1] = 8'h3C; stream[2] = 8'h0F;
    stream[3] = 8'hFF; stream[4] = 8'h81;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (readyA !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b want=0", readyA); end
    checks++; if (cinA !== 1'b0) begin failures++; $display("[TB] FAIL reset_cin got=%b want=0", cinA); end
    checks++; if (enA !== 1'b0) begin failures++; $display("[TB] FAIL reset_en got=%b want=0", enA); end
    checks++; if (nrstA !== 1'b1) begin failures++; $display("[TB] FAIL reset_nrst got=%b want=1", nrstA); end
    checks++; if (busyA !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busyA); end
    checks++; if (doneA !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", doneA); end
    reset = 1'b0;
  endtask

  task automatic test_nominal();
    setStreamA();
    runLoad(1'b0, 5, -1, 0, -1, -1, 50);
    checks++; if (nrstLowCount !== 1) begin failures++; $display("[TB] FAIL nom_nrstCount got=%0d want=1", nrstLowCount); end
    checks++; if (nrstLowFirst !== 1) begin failures++; $display("[TB] FAIL nom_nrstCycle got=%0d want=1", nrstLowFirst); end
    checks++; if (enCount !== 40) begin failures++; $display("[TB] FAIL nom_enCount got=%0d want=40", enCount); end
    checks++; if (enFirst !== 3) begin failures++; $display("[TB] FAIL nom_enFirst got=%0d want=3", enFirst); end
    checks++; if (enLast !== 42) begin failures++; $display("[TB] FAIL nom_enLast got=%0d want=42", enLast); end
    checks++; if (doneCycle !== 43) begin failures++; $display("[TB] FAIL nom_doneCycle got=%0d want=43", doneCycle); end
    checks++; if (doneCount !== 1) begin failures++; $display("[TB] FAIL nom_doneCount got=%0d want=1", doneCount); end
    checks++; if (accepted !== 5) begin failures++; $display("[TB] FAIL nom_accepted got=%0d want=5", accepted); end
    checks++; if (readyNoEn !== 1) begin failures++; $display("[TB] FAIL nom_loadCycles got=%0d want=1", readyNoEn); end
    checks++; if (chainA !== 36'h53C0FFF81) begin failures++; $display("[TB] FAIL nom_chain got=%h want=53c0fff81", chainA); end
  endtask

  task automatic test_stall();
    setStreamA();
    runLoad(1'b0, 5, 2, 5, -1, -1, 55);
    checks++; if (enCount !== 40) begin failures++; $display("[TB] FAIL stall_enCount got=%0d want=40", enCount); end
    checks++; if (enLast !== 47) begin failures++; $display("[TB] FAIL stall_enLast got=%0d want=47", enLast); end
    checks++; if (readyNoEn !== 6) begin failures++; $display("[TB] FAIL stall_loadCycles got=%0d want=6", readyNoEn); end
    checks++; if (doneCycle !== 48) begin failures++; $display("[TB] FAIL stall_doneCycle got=%0d want=48", doneCycle); end
    checks++; if (chainA !== 36'h53C0FFF81) begin failures++; $display("[TB] FAIL stall_chain got=%h want=53c0fff81", chainA); end
  endtask

  task automatic test_restart_ignored();
    setStreamA();
    runLoad(1'b0, 5, -1, 0, 20, -1, 50);
    checks++; if (accepted !== 5) begin failures++; $display("[TB] FAIL restart_accepted got=%0d want=5", accepted); end
    checks++; if (doneCount !== 1) begin failures++; $display("[TB] FAIL restart_doneCount got=%0d want=1", doneCount); end
    checks++; if (nrstLowCount !== 1) begin failures++; $display("[TB] FAIL restart_nrstCount got=%0d want=1", nrstLowCount); end
    checks++; if (doneCycle !== 43) begin failures++; $display("[TB] FAIL restart_doneCycle got=%0d want=43", doneCycle); end
  endtask

  task automatic test_mid_reset();
    setStreamA();
    runLoad(1'b0, 5, -1, 0, -1, 15, 20);
    checks++; if (postEn !== 1'b0) begin failures++; $display("[TB] FAIL midrst_en got=%b want=0", postEn); end
    checks++; if (postBusy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got=%b want=0", postBusy); end
    checks++; if (postReady !== 1'b0) begin failures++; $display("[TB] FAIL midrst_ready got=%b want=0", postReady); end
    checks++; if (postNrst !== 1'b1) begin failures++; $display("[TB] FAIL midrst_nrst got=%b want=1", postNrst); end
    runLoad(1'b0, 5, -1, 0, -1, -1, 50);
    checks++; if (enCount !== 40) begin failures++; $display("[TB] FAIL reload_enCount got=%0d want=40", enCount); end
    checks++; if (doneCycle !== 43) begin failures++; $display("[TB] FAIL reload_doneCycle got=%0d want=43", doneCycle); end
    checks++; if (chainA !== 36'h53C0FFF81) begin failures++; $display("[TB] FAIL reload_chain got=%h want=53c0fff81", chainA); end
  endtask

  task automatic test_no_padding();
    stream[0] = 8'h12; stream[1] = 8'h34; stream[2] = 8'h56;
    stream[3] = 8'h78; stream[4] = 8'h00;
    runLoad(1'b1, 4, -1, 0, -1, -1, 42);
    checks++; if (enCount !== 32) begin failures++; $display("[TB] FAIL nopad_enCount got=%0d want=32", enCount); end
    checks++; if (accepted !== 4) begin failures++; $display("[TB] FAIL nopad_accepted got=%0d want=4", accepted); end
    checks++; if (doneCycle !== 35) begin failures++; $display("[TB] FAIL nopad_doneCycle got=%0d want=35", doneCycle); end
    checks++; if (chainB !== 32'h12345678) begin failures++; $display("[TB] FAIL nopad_chain got=%h want=12345678", chainB); end
  endtask

  task automatic test_idle_valid();
    int badReady;
    int badEn;
    badReady = 0;
    badEn = 0;
    wordData  = 8'hEE;
    wordValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (readyA !== 1'b0 || readyB !== 1'b0) badReady++;
      if (enA !== 1'b0 || enB !== 1'b0) badEn++;
    end
    wordValid = 1'b0;
    checks++; if (badReady !== 0) begin failures++; $display("[TB] FAIL idle_ready got=%0d want=0", badReady); end
    checks++; if (badEn !== 0) begin failures++; $display("[TB] FAIL idle_en got=%0d want=0", badEn); end
    checks++; if (busyA !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy got=%b want=0", busyA); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    startA    = 1'b0;
    startB    = 1'b0;
    wordData  = 8'h00;
    wordValid = 1'b0;
    test_reset();
    test_nominal();
    test_stall();
    test_restart_ignored();
    test_mid_reset();
    test_no_padding();
    test_idle_valid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
